// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage next-PC controller: owns the PC, arbitrates jump/JR/branch redirects,
// holds a redirect that arrives under stall, and drives the IF/ID flushes.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [25:0] jump_index,
   input  logic [31:0] id_pc_plus4,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        flush_if,
   output logic        flush_id,
   output logic        redirect_pending,
   output logic        align_err
);

   typedef enum logic {StRun, StPend} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        pend_br_q, pend_br_d;
   logic        align_q, align_d;

   logic [31:0] jump_tgt;
   logic [31:0] live_tgt;
   logic        live_valid;

   always_comb begin
      jump_tgt   = {id_pc_plus4[31:28], jump_index, 2'b00};
      live_valid = branch_valid | jr_valid | jump_valid;
      // Branch is the older instruction, so it wins over anything in ID.
      if (branch_valid) begin
         live_tgt = branch_target;
      end else if (jr_valid) begin
         live_tgt = jr_target;
      end else begin
         live_tgt = jump_tgt;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      pend_br_d  = pend_br_q;
      align_d    = align_q;
      flush_if   = 1'b0;
      flush_id   = 1'b0;

      unique case (state_q)
         StRun: begin
            if (live_valid) begin
               align_d = align_q | (live_tgt[1:0] != 2'b00);
               if (stall) begin
                  state_d    = StPend;
                  pend_tgt_d = {live_tgt[31:2], 2'b00};
                  pend_br_d  = branch_valid;
               end else begin
                  pc_d     = {live_tgt[31:2], 2'b00};
                  flush_if = 1'b1;
                  flush_id = branch_valid;
               end
            end else if (!stall) begin
               pc_d = pc_q + 32'd4;
            end
         end
         StPend: begin
            if (stall) begin
               // Younger jump/JR never displaces a held redirect; a branch always does.
               if (branch_valid) begin
                  align_d    = align_q | (branch_target[1:0] != 2'b00);
                  pend_tgt_d = {branch_target[31:2], 2'b00};
                  pend_br_d  = 1'b1;
               end
            end else begin
               state_d  = StRun;
               flush_if = 1'b1;
               if (branch_valid) begin
                  align_d  = align_q | (branch_target[1:0] != 2'b00);
                  pc_d     = {branch_target[31:2], 2'b00};
                  flush_id = 1'b1;
               end else begin
                  pc_d     = pend_tgt_q;
                  flush_id = pend_br_q;
               end
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StRun;
         pc_q       <= RESET_PC;
         pend_tgt_q <= 32'h0;
         pend_br_q  <= 1'b0;
         align_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
         pend_br_q  <= pend_br_d;
         align_q    <= align_d;
      end
   end

   assign pc               = pc_q;
   assign pc_plus4         = pc_q + 32'd4;
   assign redirect_pending = (state_q == StPend);
   assign align_err        = align_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the next-PC rules.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        jump_valid = 1'b0;
   logic [25:0] jump_index = '0;
   logic [31:0] id_pc_plus4 = '0;
   logic        jr_valid = 1'b0;
   logic [31:0] jr_target = '0;
   logic        branch_valid = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] pc, pc_plus4;
   logic        flush_if, flush_id, redirect_pending, align_err;

   int n_vec = 0;
   int n_err = 0;

   // Model state (m_*) and its value after the coming edge (n_*).
   logic [31:0] m_pc, m_ptgt, n_pc, n_ptgt;
   bit          m_pend, m_pbr, m_align, n_pend, n_pbr, n_align;
   bit          e_fif, e_fid;

   pc_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .jump_valid(jump_valid), .jump_index(jump_index), .id_pc_plus4(id_pc_plus4),
      .jr_valid(jr_valid), .jr_target(jr_target),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .pc(pc), .pc_plus4(pc_plus4), .flush_if(flush_if), .flush_id(flush_id),
      .redirect_pending(redirect_pending), .align_err(align_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc = 32'h0; m_ptgt = 32'h0; m_pend = 0; m_pbr = 0; m_align = 0;
   endtask

   task automatic model_comb();
      logic [31:0] tgt;
      bit          any, is_br;
      n_pc = m_pc; n_ptgt = m_ptgt; n_pend = m_pend; n_pbr = m_pbr; n_align = m_align;
      e_fif = 0; e_fid = 0;
      any   = branch_valid || jr_valid || jump_valid;
      is_br = branch_valid;
      if (branch_valid) tgt = branch_target;
      else if (jr_valid) tgt = jr_target;
      else tgt = (id_pc_plus4 & 32'hF000_0000) + 32'(jump_index) * 4;
      if (!m_pend) begin
         if (!any) begin
            if (!stall) n_pc = m_pc + 4;
         end else begin
            if (tgt % 4 != 0) n_align = 1;
            if (stall) begin
               n_pend = 1; n_ptgt = tgt - tgt % 4; n_pbr = is_br;
            end else begin
               n_pc = tgt - tgt % 4; e_fif = 1; e_fid = is_br;
            end
         end
      end else if (stall) begin
         if (branch_valid) begin
            if (branch_target % 4 != 0) n_align = 1;
            n_ptgt = branch_target - branch_target % 4; n_pbr = 1;
         end
      end else begin
         n_pend = 0; e_fif = 1;
         if (branch_valid) begin
            if (branch_target % 4 != 0) n_align = 1;
            n_pc = branch_target - branch_target % 4; e_fid = 1;
         end else begin
            n_pc = m_ptgt; e_fid = m_pbr;
         end
      end
   endtask

   task automatic tick();
      model_comb();
      @(posedge clk);
      #1;
      m_pc = n_pc; m_ptgt = n_ptgt; m_pend = n_pend; m_pbr = n_pbr; m_align = n_align;
   endtask

   task automatic clear_inputs();
      stall = 0; jump_valid = 0; jr_valid = 0; branch_valid = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      #3;
      model_reset();
      n_vec++;
      if (pc !== 32'h0 || pc_plus4 !== 32'h4 || flush_if !== 1'b0 || flush_id !== 1'b0 ||
          redirect_pending !== 1'b0 || align_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset: pc=%h pc4=%h fif=%b fid=%b pend=%b aerr=%b, want 0 4 0 0 0 0",
                  pc, pc_plus4, flush_if, flush_id, redirect_pending, align_err);
      end
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_vec++;
         if (pc !== 32'(4 * i) || flush_if !== 1'b0 || flush_id !== 1'b0) begin
            n_err++;
            $display("FAIL free_run[%0d]: pc=%h fif=%b fid=%b, want pc=%h flushes 0",
                     i, pc, flush_if, flush_id, 32'(4 * i));
         end
      end
   endtask

   task automatic test_jump();
      branch_valid = 1; branch_target = 32'h40;
      tick();
      clear_inputs();
      n_vec++;
      if (pc !== 32'h40) begin
         n_err++; $display("FAIL jump_setup: pc=%h want 00000040", pc);
      end
      jump_valid = 1; jump_index = 26'h0000100; id_pc_plus4 = 32'h3000_0044;
      #1;
      n_vec++;
      if (flush_if !== 1'b1 || flush_id !== 1'b0) begin
         n_err++; $display("FAIL jump_flush: fif=%b fid=%b want 1 0", flush_if, flush_id);
      end
      tick();
      clear_inputs();
      n_vec++;
      if (pc !== 32'h3000_0400) begin
         n_err++; $display("FAIL jump_target: pc=%h want 30000400", pc);
      end
   endtask

   task automatic test_branch_priority();
      branch_valid = 1; branch_target = 32'h200;
      jump_valid = 1; jump_index = 26'h3FF_FFFF; id_pc_plus4 = 32'h5000_0000;
      #1;
      n_vec++;
      if (flush_if !== 1'b1 || flush_id !== 1'b1) begin
         n_err++; $display("FAIL br_prio_flush: fif=%b fid=%b want 1 1", flush_if, flush_id);
      end
      tick();
      clear_inputs();
      n_vec++;
      if (pc !== 32'h200) begin
         n_err++; $display("FAIL br_prio_pc: pc=%h want 00000200", pc);
      end
   endtask

   task automatic test_stall_pending();
      logic [31:0] held;
      held = pc;
      stall = 1; jr_valid = 1; jr_target = 32'h1000;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin branch_valid = 1; branch_target = 32'h80; end
         else branch_valid = 0;
         #1;
         n_vec++;
         if (flush_if !== 1'b0 || flush_id !== 1'b0) begin
            n_err++; $display("FAIL stall_flush[%0d]: fif=%b fid=%b want 0 0", i, flush_if, flush_id);
         end
         tick();
         n_vec++;
         if (pc !== held || redirect_pending !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: pc=%h pend=%b want %h 1", i, pc, redirect_pending, held);
         end
      end
      clear_inputs();
      jump_valid = 1; jump_index = 26'h1234;
      #1;
      n_vec++;
      if (flush_if !== 1'b1 || flush_id !== 1'b1) begin
         n_err++; $display("FAIL pend_release_flush: fif=%b fid=%b want 1 1", flush_if, flush_id);
      end
      tick();
      clear_inputs();
      n_vec++;
      if (pc !== 32'h80 || redirect_pending !== 1'b0) begin
         n_err++; $display("FAIL pend_release: pc=%h pend=%b want 00000080 0", pc, redirect_pending);
      end
   endtask

   task automatic test_align_and_reset();
      branch_valid = 1; branch_target = 32'h102;
      tick();
      clear_inputs();
      n_vec++;
      if (pc !== 32'h100 || align_err !== 1'b1) begin
         n_err++; $display("FAIL align: pc=%h aerr=%b want 00000100 1", pc, align_err);
      end
      tick();
      n_vec++;
      if (align_err !== 1'b1 || pc !== 32'h104) begin
         n_err++; $display("FAIL align_sticky: aerr=%b pc=%h want 1 00000104", align_err, pc);
      end
      stall = 1; jr_valid = 1; jr_target = 32'h2000;
      tick();
      n_vec++;
      if (redirect_pending !== 1'b1) begin
         n_err++; $display("FAIL pend_before_reset: pend=%b want 1", redirect_pending);
      end
      #2;
      rst_n = 0;
      #1;
      model_reset();
      n_vec++;
      if (pc !== 32'h0 || redirect_pending !== 1'b0 || align_err !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: pc=%h pend=%b aerr=%b want 0 0 0", pc, redirect_pending, align_err);
      end
      clear_inputs();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_wrap();
      branch_valid = 1; branch_target = 32'hFFFF_FFFC;
      tick();
      clear_inputs();
      n_vec++;
      if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
         n_err++; $display("FAIL wrap_setup: pc=%h pc4=%h want fffffffc 0", pc, pc_plus4);
      end
      tick();
      n_vec++;
      if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin
         n_err++; $display("FAIL wrap: pc=%h pc4=%h want 0 4", pc, pc_plus4);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom_range(0, 2) == 0);
         jump_valid    = ($urandom_range(0, 4) == 0);
         jr_valid      = ($urandom_range(0, 5) == 0);
         branch_valid  = ($urandom_range(0, 5) == 0);
         jump_index    = 26'($urandom);
         id_pc_plus4   = $urandom;
         jr_target     = $urandom & (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         branch_target = $urandom & (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         if (i == 200) begin
            rst_n = 0; #1; rst_n = 1; model_reset();
         end
         #1;
         model_comb();
         n_vec++;
         if (flush_if !== e_fif || flush_id !== e_fid) begin
            n_err++;
            $display("FAIL rnd_flush[%0d]: fif=%b fid=%b want %b %b", i, flush_if, flush_id, e_fif, e_fid);
         end
         n_vec++;
         if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || redirect_pending !== m_pend ||
             align_err !== m_align) begin
            n_err++;
            $display("FAIL rnd_state[%0d]: pc=%h pc4=%h pend=%b aerr=%b want %h %h %b %b", i, pc,
                     pc_plus4, redirect_pending, align_err, m_pc, m_pc + 32'd4, m_pend, m_align);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_jump();
      test_branch_priority();
      test_stall_pending();
      test_align_and_reset();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
